// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter: registered one-hot grant, hold while the owner requests,
// optional maximum-tenure preemption when another master is waiting.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1,
    parameter int MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]    HOLD_ONE  = (MAX_HOLD > 0) ? HW'(1) : HW'(0);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N - 1);

    logic [N-1:0]     gnt_reg, gnt_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic             gnt_valid_reg, gnt_valid_next;
    logic             preempt_reg, preempt_next;
    logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
    logic [IDX_W-1:0] last_ptr_reg, last_ptr_next;

    logic             owner_req;
    logic             expired;
    logic [N-1:0]     cand;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;

    assign owner_req = |(req & gnt_reg);
    assign expired   = (MAX_HOLD > 0) && (hold_cnt_reg == HOLD_MAX);

    // Candidates: everyone when idle, everyone but the owner on drop or expiry, nobody while holding.
    always_comb begin
        cand = '0;
        if (!gnt_valid_reg) begin
            cand = req;
        end else if (!owner_req || expired) begin
            cand = req & ~gnt_reg;
        end
    end

    always_comb begin
        int pos;
        pos     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(last_ptr_reg) + 1 + k) % N;
            if (!found && cand[pos]) begin
                found   = 1'b1;
                win_idx = IDX_W'(pos);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        gnt_next       = gnt_reg;
        gnt_idx_next   = gnt_idx_reg;
        gnt_valid_next = gnt_valid_reg;
        preempt_next   = 1'b0;
        hold_cnt_next  = hold_cnt_reg;
        last_ptr_next  = last_ptr_reg;
        if (found) begin
            gnt_next       = win_onehot;
            gnt_idx_next   = win_idx;
            gnt_valid_next = 1'b1;
            last_ptr_next  = win_idx;
            hold_cnt_next  = HOLD_ONE;
            // A winner found while the owner still requests can only come from expiry.
            preempt_next   = gnt_valid_reg && owner_req;
        end else if (gnt_valid_reg && !owner_req) begin
            gnt_next       = '0;
            gnt_valid_next = 1'b0;
            hold_cnt_next  = '0;
        end else if (gnt_valid_reg && expired) begin
            hold_cnt_next  = HOLD_ONE;
        end else if (gnt_valid_reg && (MAX_HOLD > 0) && (hold_cnt_reg != '1)) begin
            hold_cnt_next  = hold_cnt_reg + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
            hold_cnt_reg  <= '0;
            last_ptr_reg  <= LAST_INIT;
        end else begin
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
            preempt_reg   <= preempt_next;
            hold_cnt_reg  <= hold_cnt_next;
            last_ptr_reg  <= last_ptr_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;
    assign preempt   = preempt_reg;

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
Parametrised N-way round-robin bus arbiter with registered one-hot grants, grant hold while the owner keeps requesting, and an optional maximum-tenure preemption.
Successor to the fixed 4-way arbiter. Generalises channel count, fixes the round-robin pointer so it always advances, and adds an encoded grant index and a preemption indicator.
Sits between N bus masters and the shared-bus mux; gnt_idx drives the mux select directly.

Parameters:
N, 4, number of requesters (1..32)
IDX_W, $clog2(N) (min 1), width of gnt_idx
MAX_HOLD, 0, max consecutive grant cycles per tenure; 0 = unlimited (pure hold-while-requesting)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  N  request per master; bit i = master i
gnt  output  N  registered one-hot grant, all-zero when idle
gnt_idx  output  IDX_W  encoded index of current grant, holds last value when idle
gnt_valid  output  1  high when any gnt bit is set (registered)
preempt  output  1  one-cycle pulse, registered alongside the new gnt, when a tenure ended by MAX_HOLD expiry rather than by req drop

Behaviour:
- Reset (rst=1 at a clk edge): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, hold_cnt=0, last_ptr=N-1 so the first search starts at index 0. Reset mid-tenure drops the grant on the next edge, with no handover.
- State: IDLE (gnt_valid=0) or OWNED (gnt_valid=1, owner=gnt_idx).
- Search function: first set bit of the candidate vector, scanning circularly from (last_ptr+1) mod N upward. Wrap-around is required: with last_ptr=N-1 the scan starts at index 0.
- IDLE: if req!=0, the next edge loads gnt from search(req). Latency is 1 cycle, req to gnt. If req==0, stay IDLE.
- OWNED, owner's req=1, no expiry: keep the grant. Other requests are ignored.
- OWNED, owner's req=0: re-arbitrate the same cycle over req with the owner bit masked. The next edge grants the winner (zero-gap handover) or goes IDLE if no other request exists.
- Expiry (MAX_HOLD>0): hold_cnt is 1 on the first grant cycle and increments each owned cycle. When hold_cnt==MAX_HOLD and the owner still requests:
  - search over req with the owner bit masked;
  - if a winner exists, the next edge grants it and pulses preempt=1;
  - if no winner exists, the owner keeps the grant, hold_cnt reloads to 1, and preempt stays 0.
- Every new grant (from IDLE, handover, or preemption) sets last_ptr=winner and hold_cnt=1. Re-grant to the same master after IDLE is legal if it is the only requester.
- A continued hold does not move last_ptr.
- gnt is always one-hot or zero. gnt_idx equals the encoded gnt whenever gnt_valid=1.
- Simultaneous owner drop plus new requests: resolved by the circular search in the same cycle. No cycle of double grant or glitch.
- hold_cnt width is $clog2(MAX_HOLD+1). It saturates, never wraps. Logic is unused when MAX_HOLD=0.
- N=1: behaves as registered req->gnt with a 1-cycle delay. preempt is never asserted.

Test Plan:
- Reset then req=4'b1111 held: gnt sequence 0001 → owner holds indefinitely (MAX_HOLD=0). Drop req[0]: next cycle gnt=0010, gnt_idx=1.
- Rotation/wrap: N=4, each owner drops req after 2 cycles with all others requesting. Grants cycle 0→1→2→3→0, with no idle cycle between tenures.
- Fairness: last owner=2, req=4'b0101 → next gnt=0001? No: the scan starts at 3, so the winner is 0 (gnt=0001). Then owner 0 drops → gnt=0100. Repeat; no master is starved.
- Preemption: MAX_HOLD=3, req=4'b0011 held constantly. gnt=0001 for 3 cycles, then 0010 with preempt=1 for one cycle, 3 cycles later 0001 with preempt=1.
- Expiry with no competitor: MAX_HOLD=3, req=4'b1000 only. gnt=1000 continuous, preempt never asserted.
- Reset mid-tenure: owner 2 granted, assert rst one cycle with req still active. Next edge gnt=0 and gnt_valid=0. After release the first grant goes to the lowest requesting index ≥0 (last_ptr reset).
